// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding, stage indices and lock/clear vectors for hazard_scheduler
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } sched_state_t;

    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    localparam logic [3:0] LOCK_ALL     = 4'b1111;
    localparam logic [3:0] LOCK_LOADUSE = LOCK_ALL & ~(4'(1) << IFID);
    localparam logic [3:0] LOCK_MDU     = LOCK_ALL & ~((4'(1) << IFID) | (4'(1) << IDEX));

    localparam logic [3:0] CLR_NONE    = 4'b0000;
    localparam logic [3:0] CLR_ALL     = 4'b1111;
    localparam logic [3:0] CLR_BRANCH  = (4'(1) << IFID) | (4'(1) << IDEX);
    localparam logic [3:0] CLR_JUMP    = 4'(1) << IFID;
    localparam logic [3:0] CLR_LOADUSE = 4'(1) << IDEX;
    localparam logic [3:0] CLR_MDU     = 4'(1) << EXMEM;

    // Maps a 1..15 hold length to the counter preload; the detect cycle is not counted.
    function automatic logic [3:0] mdu_preload(input int latency);
        return 4'(latency - 1);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - register-compare logic flagging a load-use hazard between EX and ID
module load_use_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rt);
    assign rt_match = id_uses_rt && (id_rt == ex_rt);

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign hazard = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - pipeline lock/clear/PC scheduler with MDU hold FSM; HAZARD_PERF_EN adds stall/flush counters
module hazard_scheduler
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_is_mdu,
    input  logic       branch_taken,
    input  logic       jump,
    output logic [3:0] pipeline_lock,
    output logic [3:0] pipeline_clear,
    output logic       pc_write,
    output logic       stalled
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [3:0] MDU_LOAD = mdu_preload(MDU_LATENCY);

    sched_state_t state;
    sched_state_t next_state;
    logic [3:0]   mdu_cnt;
    logic [3:0]   next_cnt;

    logic       load_use;
    logic       mdu_hold;
    logic [3:0] lock_run;
    logic [3:0] clear_run;
    logic       pc_write_run;
    logic       stalled_run;

    load_use_detect u_load_use_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hazard      (load_use)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            mdu_cnt <= 4'd0;
        end else begin
            state   <= next_state;
            mdu_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state   = RUN;
        next_cnt     = mdu_cnt;
        lock_run     = LOCK_ALL;
        clear_run    = CLR_NONE;
        pc_write_run = 1'b1;
        stalled_run  = 1'b0;

        // In MDU_WAIT with the counter at zero this is the release cycle: the trigger is ignored.
        mdu_hold = (state == RUN) ? ex_is_mdu : (mdu_cnt != 4'd0);

        if (branch_taken) begin
            clear_run = CLR_BRANCH;
            next_cnt  = 4'd0;
        end else if (mdu_hold) begin
            lock_run     = LOCK_MDU;
            clear_run    = CLR_MDU;
            pc_write_run = 1'b0;
            stalled_run  = 1'b1;
            next_state   = MDU_WAIT;
            next_cnt     = (state == RUN) ? MDU_LOAD : mdu_cnt - 4'd1;
        end else if (load_use) begin
            lock_run     = LOCK_LOADUSE;
            clear_run    = CLR_LOADUSE;
            pc_write_run = 1'b0;
            stalled_run  = 1'b1;
        end else if (jump) begin
            clear_run = CLR_JUMP;
        end
    end

    // Reset must take effect on the outputs without waiting for a clock edge.
    assign pipeline_lock  = reset_n ? lock_run     : LOCK_ALL;
    assign pipeline_clear = reset_n ? clear_run    : CLR_ALL;
    assign pc_write       = reset_n ? pc_write_run : 1'b0;
    assign stalled        = reset_n ? stalled_run  : 1'b0;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (stalled_run) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken || jump) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed and randomized self-checking bench for hazard_scheduler
module tb_hazard_scheduler;

    localparam int LAT = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_is_mdu, branch_taken, jump;
    logic [3:0] pipeline_lock, pipeline_clear;
    logic       pc_write, stalled;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: an MDU operation is tracked by how many hold cycles it has served so far.
    bit         m_in_op, n_in_op;
    int         m_served, n_served;
    logic [3:0] e_lock, e_clear;
    logic       e_pc, e_stall;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    hazard_scheduler #(.MDU_LATENCY(LAT)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .ex_is_mdu      (ex_is_mdu),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .pipeline_lock  (pipeline_lock),
        .pipeline_clear (pipeline_clear),
        .pc_write       (pc_write),
        .stalled        (stalled)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; ex_is_mdu = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic model_eval();
        bit lu, continuing, releasing;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        continuing = m_in_op && (m_served < LAT);
        releasing  = m_in_op && (m_served >= LAT);
        n_in_op = m_in_op; n_served = m_served;
        e_lock = 4'b1111; e_clear = 4'b0000; e_pc = 1'b1; e_stall = 1'b0;
        if (branch_taken) begin
            e_clear = 4'b0011; n_in_op = 0; n_served = 0;
        end else if (continuing || (!releasing && ex_is_mdu)) begin
            e_lock = 4'b1100; e_clear = 4'b0100; e_pc = 1'b0; e_stall = 1'b1;
            n_in_op = 1; n_served = continuing ? m_served + 1 : 1;
        end else begin
            n_in_op = 0; n_served = 0;
            if (lu) begin
                e_lock = 4'b1110; e_clear = 4'b0010; e_pc = 1'b0; e_stall = 1'b1;
            end else if (jump) begin
                e_clear = 4'b0001;
            end
        end
    endtask

    task automatic tick_check();
        #1;
        model_eval();
        check_eq("lock", 32'(pipeline_lock), 32'(e_lock));
        check_eq("clear", 32'(pipeline_clear), 32'(e_clear));
        check_eq("pc_write", 32'(pc_write), 32'(e_pc));
        check_eq("stalled", 32'(stalled), 32'(e_stall));
`ifdef HAZARD_PERF_EN
        check_eq("stall_cycles", stall_cycles, m_stall_cnt);
        check_eq("flush_count", flush_count, m_flush_cnt);
`endif
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset_n) begin
            m_in_op = n_in_op;
            m_served = n_served;
            if (e_stall) m_stall_cnt = m_stall_cnt + 1;
            if (branch_taken || jump) m_flush_cnt = m_flush_cnt + 1;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_lock", 32'(pipeline_lock), 32'hF);
        check_eq("rst_clear", 32'(pipeline_clear), 32'hF);
        check_eq("rst_pc_write", 32'(pc_write), 32'h0);
        check_eq("rst_stalled", 32'(stalled), 32'h0);
        m_in_op = 0; m_served = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        do_reset();

        tick_check();
        check_eq("idle_lock", 32'(pipeline_lock), 32'hF);
        check_eq("idle_clear", 32'(pipeline_clear), 32'h0);
        check_eq("idle_pc_write", 32'(pc_write), 32'h1);
        advance();

        ex_is_mdu = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            tick_check();
            check_eq("mdu_lock", 32'(pipeline_lock), 32'hC);
            check_eq("mdu_clear", 32'(pipeline_clear), 32'h4);
            check_eq("mdu_pc_write", 32'(pc_write), 32'h0);
            advance();
        end
        tick_check();
        check_eq("mdu_release_lock", 32'(pipeline_lock), 32'hF);
        check_eq("mdu_release_stalled", 32'(stalled), 32'h0);
        advance();
        ex_is_mdu = 1'b0;
        branch_taken = 1'b1;
        tick_check();
        advance();
        idle();
        tick_check();
`ifdef HAZARD_PERF_EN
        check_eq("perf_stall_cycles", stall_cycles, 32'd4);
        check_eq("perf_flush_count", flush_count, 32'd1);
`endif
        advance();

        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        tick_check();
        check_eq("lu_lock", 32'(pipeline_lock), 32'hE);
        check_eq("lu_clear", 32'(pipeline_clear), 32'h2);
        check_eq("lu_stalled", 32'(stalled), 32'h1);
        advance();
        ex_rt = 5'd0; id_rs = 5'd0;
        tick_check();
        check_eq("lu_r0_stalled", 32'(stalled), 32'h0);
        check_eq("lu_r0_lock", 32'(pipeline_lock), 32'hF);
        advance();
        idle();

        ex_is_mdu = 1'b1;
        tick_check(); advance();
        ex_is_mdu = 1'b0;
        tick_check(); advance();
        branch_taken = 1'b1;
        tick_check();
        check_eq("br_in_mdu_lock", 32'(pipeline_lock), 32'hF);
        check_eq("br_in_mdu_clear", 32'(pipeline_clear), 32'h3);
        check_eq("br_in_mdu_pc_write", 32'(pc_write), 32'h1);
        advance();
        branch_taken = 1'b0;
        tick_check();
        check_eq("after_br_stalled", 32'(stalled), 32'h0);
        advance();

        branch_taken = 1'b1; jump = 1'b1;
        tick_check();
        check_eq("br_jump_clear", 32'(pipeline_clear), 32'h3);
        advance();
        branch_taken = 1'b0;
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        tick_check();
        check_eq("lu_jump_lock", 32'(pipeline_lock), 32'hE);
        check_eq("lu_jump_clear", 32'(pipeline_clear), 32'h2);
        advance();
        idle();

        ex_is_mdu = 1'b1;
        tick_check(); advance();
        tick_check(); advance();
        do_reset();
        ex_is_mdu = 1'b0;
        tick_check();
        check_eq("post_rst_lock", 32'(pipeline_lock), 32'hF);
        advance();

        for (int n = 0; n < 3000; n++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom_range(0, 1));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            ex_is_mdu    = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            jump         = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            tick_check();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

- Sequences the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage pipeline.
- Arbitrates between four hazard sources:
  - taken-branch redirect (resolved in EX)
  - jump redirect (ID)
  - load-use interlock
  - multi-cycle multiply/divide hold
- Drives per-stage write-enable (lock) and synchronous-clear vectors plus the PC write enable.
- Replaces the fixed lock/clear mapping with a stateful scheduler that owns the MDU hold counter.

## Interface
Parameters:
- MDU_LATENCY, 4: total cycles the pipeline holds for a mult/div in EX; legal range 2..15.

Ports:
- clock  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads rs / rt
- ex_mem_read  in  1  the instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- ex_is_mdu  in  1  the instruction in EX is mult/div
- branch_taken  in  1  the branch in EX is taken
- jump  in  1  the instruction in ID is a jump
- pipeline_lock  out  4  bit0 = IF/ID … bit3 = MEM/WB; 1 = write, 0 = hold
- pipeline_clear  out  4  same bit order; 1 = clear to bubble
- pc_write  out  1  1 = PC updates this cycle
- stalled  out  1  1 = any hold is active this cycle

## Operation
- FSM states are RUN and MDU_WAIT. The 4-bit down-counter `mdu_cnt` is registered.
- Outputs are combinational from the current state and inputs. State and counter update on the rising clock edge.
- Priority, highest first:
  1. branch_taken: lock=1111, clear=0011, pc_write=1, stalled=0. The next state is RUN and mdu_cnt is loaded with 0, so a branch aborts an MDU hold.
  2. MDU hold (see below).
  3. Load-use: condition is ex_mem_read, ex_rt≠0, and (id_uses_rs with id_rs==ex_rt, or id_uses_rt with id_rt==ex_rt).
     - Outputs: lock=1110, clear=0010, pc_write=0, stalled=1.
     - State stays RUN.
  4. jump: lock=1111, clear=0001, pc_write=1.
  5. Default: lock=1111, clear=0000, pc_write=1, stalled=0.
- MDU hold behaviour:
  - RUN with ex_is_mdu=1: lock=1100, clear=0100, pc_write=0, stalled=1. Load mdu_cnt=MDU_LATENCY-1 and go to MDU_WAIT.
  - MDU_WAIT with mdu_cnt≠0: same hold outputs, and mdu_cnt decrements.
  - MDU_WAIT with mdu_cnt==0: release cycle. The MDU trigger is ignored and priorities 3–5 apply. Next state is RUN.
- A load-use stall while IF/ID is already held, or a jump, cannot coincide with an MDU hold. The priority order covers them anyway.
- ex_rt==0 never stalls.

## Timing
- Reset (reset_n=0), effective immediately and independent of clock:
  - state=RUN, mdu_cnt=0
  - lock=1111, clear=1111, pc_write=0, stalled=0
- The first rising edge after deassertion sees default outputs if inputs are idle.
- Latency:
  - Load-use costs exactly 1 bubble.
  - Branch costs 2 cleared stages.
  - Jump costs 1.
  - An MDU costs exactly MDU_LATENCY hold cycles: the detect cycle plus MDU_LATENCY-1 cycles in MDU_WAIT. The following cycle releases.
- Reset asserted mid-MDU_WAIT aborts the hold. After release, the MDU is not re-triggered unless ex_is_mdu is still high in RUN.
- Back-to-back MDUs: the second is detected in the cycle after release, with no gap cycle.

## Configuration
- HAZARD_PERF_EN defined adds two outputs:
  - stall_cycles[31:0]: +1 on every cycle with stalled=1
  - flush_count[31:0]: +1 on every cycle with branch_taken=1 or jump=1
- Both counters reset to 0 and wrap modulo 2^32.
- HAZARD_PERF_EN undefined: both ports and their registers are absent, and all other behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - state encoding: RUN=0, MDU_WAIT=1
  - stage bit indices: IFID=0, IDEX=1, EXMEM=2, MEMWB=3
  - named vectors: LOCK_ALL=1111, LOCK_LOADUSE=1110, LOCK_MDU=1100, CLR_NONE=0000, CLR_BRANCH=0011, CLR_JUMP=0001, CLR_LOADUSE=0010, CLR_MDU=0100
- One combinational sub-module, load_use_detect: the register-compare logic producing a single hazard bit.

## Test plan
- Reset held for 3 cycles → lock=1111, clear=1111, pc_write=0. After release, with idle inputs → lock=1111, clear=0000, pc_write=1.
- ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle → lock=1110, clear=0010, pc_write=0, stalled=1. Repeating with ex_rt=0 → no stall.
- ex_is_mdu=1 held, MDU_LATENCY=4 → exactly 4 cycles of lock=1100/clear=0100/pc_write=0, then 1 release cycle with lock=1111.
- branch_taken=1 in the 2nd cycle of MDU_WAIT → that cycle lock=1111, clear=0011, pc_write=1. Next cycle state RUN, no further hold.
- branch_taken=1 and jump=1 together → clear=0011, not 0001. Load-use plus jump → load-use outputs win.
- With HAZARD_PERF_EN, after the MDU scenario and one branch → stall_cycles=4, flush_count=1.
